// File: rtl/mdsa_pkg.sv
// Shared types for the MDSA job arbiter.
//  - state_e: arbiter FSM encoding (IDLE, LOAD, START, BUSY, DONE)
//  - NUM_REQ_DEF: default requester count
package mdsa_pkg;

   localparam int unsigned NUM_REQ_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_BUSY  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/mdsa_rr_picker.sv
// Combinational round-robin picker.
//  req      : request vector
//  rr_ptr   : index of the last winner; scanning starts one above it
//  any_c    : at least one request is set
//  winner_c : binary index of the first set request after rr_ptr (mod NUM_REQ)
//  onehot_c : one-hot form of winner_c, zero when nothing is requested
module mdsa_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic               any_c,
   output logic [IW-1:0]      winner_c,
   output logic [NUM_REQ-1:0] onehot_c
);

   // Scan offsets 1..NUM_REQ from rr_ptr; the first hit wins.
   always_comb begin
      int unsigned idx;
      any_c    = 1'b0;
      winner_c = '0;
      idx      = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = (32'(rr_ptr) + off) % NUM_REQ;
         if (!any_c && req[IW'(idx)]) begin
            any_c    = 1'b1;
            winner_c = IW'(idx);
         end
      end
      onehot_c = any_c ? (NUM_REQ'(1) << winner_c) : '0;
   end

endmodule

// File: rtl/mdsa_job_arbiter.sv
// Round-robin arbiter sharing one MDSA sorter core among NUM_REQ requesters.
//  clk, rst   : clock and synchronous active-high reset
//  req        : level request per requester
//  gnt, sel   : one-hot grant and binary index of the served requester (core input mux)
//  sort_ready : core idle
//  sort_load  : core input capture enable, held LOAD_CYCLES cycles
//  sort_start : one-cycle START pulse to the core
//  sort_oe    : core result-valid pulse, honoured only while BUSY
//  done, err  : one-cycle completion pulse to the requester; err flags a core timeout
//  busy       : arbiter is not idle
module mdsa_job_arbiter
   import mdsa_pkg::*;
#(
   parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
   parameter int unsigned LOAD_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 128,
   localparam int unsigned IW = $clog2(NUM_REQ),
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1),
   localparam int unsigned LW = $clog2(LOAD_CYCLES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      sel,
   input  logic               sort_ready,
   output logic               sort_load,
   output logic               sort_start,
   input  logic               sort_oe,
   output logic [NUM_REQ-1:0] done,
   output logic               err,
   output logic               busy
);

   state_e               state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [LW-1:0]        load_cnt_q, load_cnt_d;
   logic [TW-1:0]        timer_q, timer_d, timer_inc;
   logic [NUM_REQ-1:0]   gnt_d, done_d;
   logic [IW-1:0]        sel_d;
   logic                 load_d, start_d, err_d, busy_d;

   logic                 pick_any;
   logic [IW-1:0]        pick_winner;
   logic [NUM_REQ-1:0]   pick_onehot;

   mdsa_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req      (req),
      .rr_ptr   (rr_ptr_q),
      .any_c    (pick_any),
      .winner_c (pick_winner),
      .onehot_c (pick_onehot)
   );

   // Next state and next values of all registered outputs.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      load_cnt_d = load_cnt_q;
      timer_d    = timer_q;
      gnt_d      = gnt;
      sel_d      = sel;
      load_d     = 1'b0;
      start_d    = 1'b0;
      done_d     = '0;
      err_d      = 1'b0;
      // Saturating increment; expiry is judged on the value about to be reached.
      timer_inc  = (timer_q == TW'(TIMEOUT_CYCLES)) ? timer_q : timer_q + TW'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (pick_any && sort_ready) begin
               state_d    = ST_LOAD;
               gnt_d      = pick_onehot;
               sel_d      = pick_winner;
               rr_ptr_d   = pick_winner;
               load_cnt_d = '0;
               load_d     = 1'b1;
            end
         end
         ST_LOAD: begin
            if (load_cnt_q == LW'(LOAD_CYCLES - 1)) begin
               state_d = ST_START;
               start_d = 1'b1;
            end else begin
               load_cnt_d = load_cnt_q + LW'(1);
               load_d     = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_BUSY;
            timer_d = '0;
         end
         ST_BUSY: begin
            timer_d = timer_inc;
            // sort_oe takes precedence over a coincident expiry.
            if (sort_oe) begin
               state_d = ST_DONE;
               done_d  = gnt;
            end else if (timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_DONE;
               done_d  = gnt;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            sel_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            sel_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= IW'(NUM_REQ - 1);
         load_cnt_q <= '0;
         timer_q    <= '0;
         gnt        <= '0;
         sel        <= '0;
         sort_load  <= 1'b0;
         sort_start <= 1'b0;
         done       <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         load_cnt_q <= load_cnt_d;
         timer_q    <= timer_d;
         gnt        <= gnt_d;
         sel        <= sel_d;
         sort_load  <= load_d;
         sort_start <= start_d;
         done       <= done_d;
         err        <= err_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_mdsa_job_arbiter.sv
// Self-checking bench for mdsa_job_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a job-level model.
module tb_mdsa_job_arbiter;

   localparam int N = 4;
   localparam int L = 2;
   localparam int T = 128;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt;
   logic [1:0]   sel;
   logic         sort_ready = 1'b1;
   logic         sort_load;
   logic         sort_start;
   logic         sort_oe = 1'b0;
   logic [N-1:0] done;
   logic         err;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Job-level model: m_k is the position of the current cycle inside a job
   // (0 = idle, 1 = first load cycle, L+1 = start, then busy cycles, then done).
   int           m_k = 0;
   int           m_done_k = -1;
   bit           m_err = 1'b0;
   int           m_win = 0;
   int           m_rr = N - 1;
   logic [N-1:0] e_gnt, e_done;
   logic         e_load, e_start, e_err, e_busy;

   always #5 clk = ~clk;

   mdsa_job_arbiter #(.NUM_REQ(N), .LOAD_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt        (gnt),
      .sel        (sel),
      .sort_ready (sort_ready),
      .sort_load  (sort_load),
      .sort_start (sort_start),
      .sort_oe    (sort_oe),
      .done       (done),
      .err        (err),
      .busy       (busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Advance the model across one clock edge using the inputs seen at that edge.
   task automatic model_step();
      bit found;
      if (rst) begin
         m_k = 0; m_rr = N - 1; m_done_k = -1; m_err = 1'b0;
      end else if (m_k == 0) begin
         if (req != '0 && sort_ready) begin
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
               if (!found && (((req >> ((m_rr + off) % N)) & 1) != 0)) begin
                  found = 1'b1;
                  m_win = (m_rr + off) % N;
               end
            end
            m_rr = m_win; m_k = 1; m_done_k = -1; m_err = 1'b0;
         end
      end else if (m_k == m_done_k) begin
         m_k = 0;
      end else begin
         if (m_k >= L + 2 && m_done_k < 0) begin
            if (sort_oe) m_done_k = m_k + 1;
            else if (m_k - (L + 1) == T - 1) begin
               m_done_k = m_k + 1; m_err = 1'b1;
            end
         end
         m_k++;
      end
      e_busy  = (m_k != 0);
      e_gnt   = (m_k != 0) ? N'(32'd1 << m_win) : '0;
      e_load  = (m_k >= 1 && m_k <= L);
      e_start = (m_k == L + 1);
      e_done  = (m_k != 0 && m_k == m_done_k) ? e_gnt : '0;
      e_err   = (e_done != '0) && m_err;
   endtask

   // Single compare process: model update at the edge, DUT sampled 1 time unit later.
   always @(posedge clk) begin
      model_step();
      #1;
      check("m_gnt",   32'(gnt),        32'(e_gnt));
      check("m_load",  32'(sort_load),  32'(e_load));
      check("m_start", 32'(sort_start), 32'(e_start));
      check("m_done",  32'(done),       32'(e_done));
      check("m_err",   32'(err),        32'(e_err));
      check("m_busy",  32'(busy),       32'(e_busy));
      if (m_k != 0) check("m_sel", 32'(sel), 32'(m_win));
   end

   task automatic do_reset();
      rst = 1'b1; req = '0; sort_oe = 1'b0; sort_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_gnt",  32'(gnt),  32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sel",  32'(sel),  32'd0);
      rst = 1'b0;
   endtask

   task automatic wait_start(input string nm);
      int n = 0;
      while (sort_start !== 1'b1 && n < 100) begin
         @(negedge clk); n++;
      end
      check({nm, "_start"}, 32'(sort_start), 32'd1);
   endtask

   // From the START cycle: drive oe d busy cycles later (0 = never), optionally drop req.
   task automatic finish_job(input string nm, input int d, input int drop_at,
                             input logic [N-1:0] exp_g, input bit exp_e, input int exp_lat);
      int lat = 0;
      do begin
         @(negedge clk); lat++;
         if (lat == drop_at) req = '0;
         sort_oe = (done == '0) && (lat == d);
      end while (done == '0 && lat < 200);
      sort_oe = 1'b0;
      check({nm, "_lat"},  32'(lat),  32'(exp_lat));
      check({nm, "_done"}, 32'(done), 32'(exp_g));
      check({nm, "_err"},  32'(err),  32'(exp_e));
      @(negedge clk);
      check({nm, "_idle_busy"}, 32'(busy), 32'd0);
      check({nm, "_idle_gnt"},  32'(gnt),  32'd0);
   endtask

   task automatic job(input string nm, input logic [N-1:0] r, input int d,
                      input logic [N-1:0] exp_g, input bit exp_e, input int exp_lat);
      req = r;
      wait_start(nm);
      check({nm, "_gnt"}, 32'(gnt), 32'(exp_g));
      finish_job(nm, d, 0, exp_g, exp_e, exp_lat);
   endtask

   initial begin
      int d;
      do_reset();

      // 1: single requester, oe 70 cycles after start
      req = 4'b0001;
      @(negedge clk);
      check("t1_c1_gnt",  32'(gnt), 32'h1);
      check("t1_c1_load", 32'(sort_load), 32'd1);
      check("t1_c1_sel",  32'(sel), 32'd0);
      @(negedge clk);
      check("t1_c2_load", 32'(sort_load), 32'd1);
      check("t1_c2_start", 32'(sort_start), 32'd0);
      @(negedge clk);
      check("t1_c3_start", 32'(sort_start), 32'd1);
      check("t1_c3_load",  32'(sort_load), 32'd0);
      check("t1_c3_gnt",   32'(gnt), 32'h1);
      finish_job("t1", 70, 0, 4'b0001, 1'b0, 71);
      req = '0;

      // 2: all requesting after reset, rotating order with wrap
      do_reset();
      job("t2a", 4'b1111, 3, 4'b0001, 1'b0, 4);
      job("t2b", 4'b1111, 3, 4'b0010, 1'b0, 4);
      job("t2c", 4'b1111, 3, 4'b0100, 1'b0, 4);
      job("t2d", 4'b1111, 3, 4'b1000, 1'b0, 4);
      job("t2e", 4'b1111, 3, 4'b0001, 1'b0, 4);

      // 3: core not ready holds off any grant
      do_reset();
      req = 4'b0101; sort_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_nogrant", 32'(gnt), 32'd0);
      end
      sort_ready = 1'b1;
      job("t3a", 4'b0101, 2, 4'b0001, 1'b0, 3);
      job("t3b", 4'b0101, 2, 4'b0100, 1'b0, 3);

      // 4: core never answers -> timeout
      job("t4", 4'b0001, 0, 4'b0001, 1'b1, 128);

      // 5: reset during BUSY cycle 20
      req = 4'b0001;
      wait_start("t5");
      repeat (20) @(negedge clk);
      rst = 1'b1; req = '0;
      @(negedge clk);
      check("t5_gnt",  32'(gnt),  32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_err",  32'(err),  32'd0);
      rst = 1'b0;
      job("t5a", 4'b1111, 4, 4'b0001, 1'b0, 5);
      job("t5b", 4'b0010, 4, 4'b0010, 1'b0, 5);

      // 6: requester drops req mid-BUSY; oe coincides with expiry
      req = 4'b0100;
      wait_start("t6");
      finish_job("t6", 127, 5, 4'b0100, 1'b0, 128);

      // Randomized traffic with spurious oe outside BUSY and occasional reset
      d = 1;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk);
         rst = ($urandom % 500 == 0);
         if ($urandom % 8 == 0) req = N'($urandom);
         sort_ready = ($urandom % 4 != 0);
         if (m_k == 1) begin
            case ($urandom % 10)
               0:       d = 0;
               1:       d = 127;
               2:       d = 126;
               default: d = 1 + int'($urandom % 15);
            endcase
         end
         if (m_k >= L + 2 && m_done_k < 0) sort_oe = (m_k - (L + 1) == d);
         else sort_oe = ($urandom % 3 == 0);
      end
      rst = 1'b0; sort_oe = 1'b0; req = '0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
